// File: rtl/frame_tx.sv
// Serial frame transmitter: shifts out SYNC_PAT then the payload MSB-first on one line.
// Define FRAME_TX_PARITY_EN to append an even-parity bit after the payload.
module frame_tx #(
   parameter int unsigned         DATA_W   = 8,
   parameter int unsigned         SYNC_W   = 4,
   parameter logic [SYNC_W-1:0]   SYNC_PAT = 4'b1010
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready,
   output logic              out,
   output logic              busy,
   output logic              done
);

   localparam int unsigned      FRAME_W  = SYNC_W + DATA_W;
   localparam int unsigned      CNT_W    = $clog2(FRAME_W + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef FRAME_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2, PAR = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, DATA = 2'd2} state_t;
`endif

   state_t             state;
   logic [FRAME_W-1:0] shreg;
   logic [CNT_W-1:0]   cnt;
`ifdef FRAME_TX_PARITY_EN
   logic               par;
`endif

   // Header and payload share one shift register; cnt holds the bits still to send.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
         out   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         ready <= 1'b1;
`ifdef FRAME_TX_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start && ready) begin
                  state <= SYNC;
                  shreg <= {SYNC_PAT, data_in} << 1;
                  cnt   <= CNT_LOAD;
                  out   <= SYNC_PAT[SYNC_W-1];
                  busy  <= 1'b1;
                  ready <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
                  par   <= ^data_in;
`endif
               end
            end
            SYNC: begin
               out   <= shreg[FRAME_W-1];
               shreg <= {shreg[FRAME_W-2:0], 1'b0};
               cnt   <= cnt - CNT_ONE;
               if (cnt == CNT_DATA)
                  state <= DATA;
            end
            DATA: begin
               if (cnt == '0) begin
`ifdef FRAME_TX_PARITY_EN
                  out   <= par;
                  state <= PAR;
`else
                  state <= IDLE;
                  out   <= 1'b0;
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  done  <= 1'b1;
`endif
               end else begin
                  out   <= shreg[FRAME_W-1];
                  shreg <= {shreg[FRAME_W-2:0], 1'b0};
                  cnt   <= cnt - CNT_ONE;
               end
            end
`ifdef FRAME_TX_PARITY_EN
            PAR: begin
               state <= IDLE;
               out   <= 1'b0;
               busy  <= 1'b0;
               ready <= 1'b1;
               done  <= 1'b1;
            end
`endif
            default: begin
               state <= IDLE;
               out   <= 1'b0;
               busy  <= 1'b0;
               ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx: a frame-level model queues expected frames, a monitor checks them.
`timescale 1ns/1ps
module tb_frame_tx;

   localparam int unsigned       DATA_W   = 8;
   localparam int unsigned       SYNC_W   = 4;
   localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1010;
`ifdef FRAME_TX_PARITY_EN
   localparam int unsigned       L = SYNC_W + DATA_W + 1;
`else
   localparam int unsigned       L = SYNC_W + DATA_W;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [DATA_W-1:0] data_in = '0;
   logic              ready, out, busy, done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [L-1:0]      bits;
      logic [DATA_W-1:0] word;
      int                done_cyc;
   } exp_t;

   exp_t exp_q[$];
   logic cap_q[$];
   int   cyc = 0;
   bit   armed = 1'b0;
   bit   act = 1'b0;
   int   acc = 0;
   bit   exp_busy = 1'b0;
   bit   exp_done = 1'b0;

   always #5 clk = ~clk;

   frame_tx #(
      .DATA_W  (DATA_W),
      .SYNC_W  (SYNC_W),
      .SYNC_PAT(SYNC_PAT)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .data_in(data_in),
      .ready  (ready),
      .out    (out),
      .busy   (busy),
      .done   (done)
   );

   function automatic logic [L-1:0] frame_of(input logic [DATA_W-1:0] d);
`ifdef FRAME_TX_PARITY_EN
      return {SYNC_PAT, d, ^d};
`else
      return {SYNC_PAT, d};
`endif
   endfunction

   function automatic void chk(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", name, cyc, got, want);
      end
   endfunction

   // Reference model: one frame of L line cycles per accept, next accept one edge after done.
   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         armed = 1'b1;
         act   = 1'b0;
         exp_q.delete();
      end else if (armed && start && (!act || cyc > acc + int'(L))) begin
         act        = 1'b1;
         acc        = cyc;
         e.bits     = frame_of(data_in);
         e.word     = data_in;
         e.done_cyc = cyc + int'(L);
         exp_q.push_back(e);
      end
      exp_busy = act && (cyc < acc + int'(L));
      exp_done = act && (cyc == acc + int'(L));
   end

   // Monitor: per-cycle handshake checks, plus whole-frame compare on each done pulse.
   always @(negedge clk) begin
      exp_t         e;
      logic [L-1:0] v;
      if (armed) begin
         chk("busy", busy, exp_busy);
         chk("done", done, exp_done);
         chk("ready", ready, !exp_busy);
         if (!exp_busy) chk("idle_out", out, 1'b0);
         if (busy) cap_q.push_back(out);
         if (done) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done cyc=%0d got=done exp=no_frame", cyc);
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (cap_q.size() != int'(L)) begin
                  errors++;
                  $display("FAIL frame_len word=%h got=%0d exp=%0d", e.word, cap_q.size(), L);
               end else begin
                  v = '0;
                  foreach (cap_q[i]) v = {v[L-2:0], cap_q[i]};
                  checks++;
                  if (v !== e.bits) begin
                     errors++;
                     $display("FAIL frame_bits word=%h got=%b exp=%b", e.word, v, e.bits);
                  end
               end
               checks++;
               if (cyc != e.done_cyc) begin
                  errors++;
                  $display("FAIL done_time word=%h got=%0d exp=%0d", e.word, cyc, e.done_cyc);
               end
            end
         end
         if (!busy) cap_q.delete();
      end
   end

   task automatic drive(input logic r, input logic s, input logic [DATA_W-1:0] d, input int n);
      repeat (n) begin
         @(negedge clk);
         rst_n   = r;
         start   = s;
         data_in = d;
      end
   endtask

   initial begin
      // Reset with start asserted
      drive(1'b0, 1'b1, 8'hA5, 2);
      // Single frame
      drive(1'b1, 1'b1, 8'hA5, 1);
      drive(1'b1, 1'b0, 8'h00, L + 3);
      // Start while busy is ignored
      drive(1'b1, 1'b1, 8'hFF, 1);
      drive(1'b1, 1'b0, 8'h00, 4);
      drive(1'b1, 1'b1, 8'h00, 3);
      drive(1'b1, 1'b0, 8'h00, L + 2);
      // Back-to-back with start held high
      drive(1'b1, 1'b1, 8'h0F, L + 1);
      drive(1'b1, 1'b1, 8'hF0, 1);
      drive(1'b1, 1'b0, 8'h00, L + 3);
      // Reset mid-frame, then a full frame
      drive(1'b1, 1'b1, 8'hC3, 1);
      drive(1'b1, 1'b0, 8'h00, 5);
      drive(1'b0, 1'b0, 8'h00, 1);
      drive(1'b1, 1'b0, 8'h00, 2);
      drive(1'b1, 1'b1, 8'h3C, 1);
      drive(1'b1, 1'b0, 8'h00, L + 3);
      // Parity-oriented payloads
      drive(1'b1, 1'b1, 8'h07, 1);
      drive(1'b1, 1'b0, 8'h00, L + 2);
      drive(1'b1, 1'b1, 8'h03, 1);
      drive(1'b1, 1'b0, 8'h00, L + 2);
      // Random traffic with occasional resets
      repeat (600) begin
         drive(logic'($urandom_range(0, 79) != 0), logic'($urandom_range(0, 2) == 0),
               DATA_W'($urandom), 1);
      end
      drive(1'b1, 1'b0, 8'h00, L + 5);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_frames got=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
